// File: rtl/conv_mem_pkg.sv
// conv_mem_pkg
// Shared constants and helpers for the convolution operand store.
//   DEF_DW / DEF_IMG_DIM / DEF_K_DIM : default element width and tile sizes
//   IMG_W / KER_W                     : flattened image / kernel widths (defaults)
//   SUM_W                             : width of the unsigned image-element sum (defaults)
//   elem_lsb(r, c, dim, dw)           : bit LSB of element (r,c) in a row-major flat vector
package conv_mem_pkg;

  localparam int DEF_DW      = 8;
  localparam int DEF_IMG_DIM = 4;
  localparam int DEF_K_DIM   = 3;

  localparam int IMG_W = DEF_IMG_DIM * DEF_IMG_DIM * DEF_DW;
  localparam int KER_W = DEF_K_DIM * DEF_K_DIM * DEF_DW;
  localparam int SUM_W = DEF_DW + $clog2(DEF_IMG_DIM * DEF_IMG_DIM);

  function automatic int elem_lsb(input int r, input int c, input int dim,
                                  input int dw = DEF_DW);
    return (r * dim + c) * dw;
  endfunction

endpackage

// File: rtl/conv_operand_bank.sv
// conv_operand_bank
// One storage bank of the operand ping-pong: holds an image tile and a kernel,
// loaded together when we_i is high. Async active-low reset clears the bank.
// Optional macro OPERAND_SUM_EN adds a stored image-element sum.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   we_i       : load img_i/ker_i (and sum_i) on this rising edge
//   img_i/ker_i: data to store
//   img_o/ker_o: stored data
//   sum_i/sum_o: stored image sum (OPERAND_SUM_EN only)
module conv_operand_bank
  import conv_mem_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int IMG_DIM = DEF_IMG_DIM,
  parameter int K_DIM   = DEF_K_DIM,
  localparam int IMG_BITS = IMG_DIM * IMG_DIM * DW,
  localparam int KER_BITS = K_DIM * K_DIM * DW
`ifdef OPERAND_SUM_EN
  , localparam int SUM_BITS = DW + $clog2(IMG_DIM * IMG_DIM)
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [IMG_BITS-1:0] img_i,
  input  logic [KER_BITS-1:0] ker_i,
  output logic [IMG_BITS-1:0] img_o,
  output logic [KER_BITS-1:0] ker_o
`ifdef OPERAND_SUM_EN
  , input  logic [SUM_BITS-1:0] sum_i
  , output logic [SUM_BITS-1:0] sum_o
`endif
);

  logic [IMG_BITS-1:0] img_q;
  logic [KER_BITS-1:0] ker_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_q <= '0;
      ker_q <= '0;
    end else if (we_i) begin
      img_q <= img_i;
      ker_q <= ker_i;
    end
  end

  assign img_o = img_q;
  assign ker_o = ker_q;

`ifdef OPERAND_SUM_EN
  logic [SUM_BITS-1:0] sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (we_i) begin
      sum_q <= sum_i;
    end
  end

  assign sum_o = sum_q;
`endif

endmodule

// File: rtl/conv_operand_pingpong.sv
// conv_operand_pingpong
// Two-bank ping-pong operand store between the loader and the convolution
// compute array. One image tile + one kernel are captured per beat into the
// write bank; the read bank is presented to the consumer until released.
// Optional macro OPERAND_SUM_EN adds img_sum (unsigned sum of image elements,
// stored per bank and presented with img_out).
//
// Handshake: a set is captured on a rising edge where in_valid && in_ready;
// in_ready = !clear && occupancy < 2 (combinational). The presented set is
// released on a rising edge where out_release && out_valid; out_valid means the
// read bank is full. img_out/ker_out are stale (bank rd_ptr) when out_valid=0.
// clear flushes occupancy and pointers and overrides capture/release.
//
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   clear                : synchronous flush of occupancy/pointers
//   in_valid, in_ready   : capture handshake
//   img_in, ker_in       : flattened operand set, element (r,c) at (r*DIM+c)*DW
//   activate_done        : one-cycle pulse after each capture edge
//   out_valid, out_release : consumer handshake
//   img_out, ker_out     : presented set (bank rd_ptr)
//   out_bank             : index of the presented bank
//   occupancy            : number of full banks (0..2)
//   img_sum              : presented image sum (OPERAND_SUM_EN only)
module conv_operand_pingpong
  import conv_mem_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int IMG_DIM = DEF_IMG_DIM,
  parameter int K_DIM   = DEF_K_DIM,
  localparam int IMG_BITS = IMG_DIM * IMG_DIM * DW,
  localparam int KER_BITS = K_DIM * K_DIM * DW
`ifdef OPERAND_SUM_EN
  , localparam int SUM_BITS = DW + $clog2(IMG_DIM * IMG_DIM)
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IMG_BITS-1:0] img_in,
  input  logic [KER_BITS-1:0] ker_in,
  output logic                activate_done,
  output logic                out_valid,
  input  logic                out_release,
  output logic [IMG_BITS-1:0] img_out,
  output logic [KER_BITS-1:0] ker_out,
  output logic                out_bank,
  output logic [1:0]          occupancy
`ifdef OPERAND_SUM_EN
  , output logic [SUM_BITS-1:0] img_sum
`endif
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] occ_q, occ_d;
  logic       act_q, act_d;
  logic       cap, rel;

  logic [IMG_BITS-1:0] bank_img [2];
  logic [KER_BITS-1:0] bank_ker [2];

  assign in_ready  = !clear && (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign cap       = in_valid && in_ready;
  // clear wins over a same-cycle release; capture is already blocked by in_ready.
  assign rel       = out_release && out_valid && !clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    act_d    = 1'b0;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      occ_d    = 2'd0;
    end else begin
      if (cap) begin
        wr_ptr_d = ~wr_ptr_q;
        act_d    = 1'b1;
      end
      if (rel) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      // Simultaneous capture and release leaves occupancy unchanged.
      if (cap && !rel) begin
        occ_d = occ_q + 2'd1;
      end else if (!cap && rel) begin
        occ_d = occ_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      act_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      act_q    <= act_d;
    end
  end

`ifdef OPERAND_SUM_EN
  logic [SUM_BITS-1:0] sum_in;
  logic [SUM_BITS-1:0] bank_sum [2];

  always_comb begin
    sum_in = '0;
    for (int r = 0; r < IMG_DIM; r++) begin
      for (int c = 0; c < IMG_DIM; c++) begin
        sum_in = sum_in + SUM_BITS'(img_in[elem_lsb(r, c, IMG_DIM, DW) +: DW]);
      end
    end
  end
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    conv_operand_bank #(
      .DW      (DW),
      .IMG_DIM (IMG_DIM),
      .K_DIM   (K_DIM)
    ) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we_i  (cap && (wr_ptr_q == 1'(b))),
      .img_i (img_in),
      .ker_i (ker_in),
      .img_o (bank_img[b]),
      .ker_o (bank_ker[b])
`ifdef OPERAND_SUM_EN
      , .sum_i (sum_in)
      , .sum_o (bank_sum[b])
`endif
    );
  end

  assign img_out       = bank_img[rd_ptr_q];
  assign ker_out       = bank_ker[rd_ptr_q];
  assign out_bank      = rd_ptr_q;
  assign occupancy     = occ_q;
  assign activate_done = act_q;

`ifdef OPERAND_SUM_EN
  assign img_sum = bank_sum[rd_ptr_q];
`endif

endmodule

// File: tb/tb_conv_operand_pingpong.sv
// tb_conv_operand_pingpong
// Self-checking bench for conv_operand_pingpong: directed scenario tasks plus a
// randomized run compared against a two-slot FIFO reference model.
module tb_conv_operand_pingpong;

  localparam int DW      = 8;
  localparam int IMG_DIM = 4;
  localparam int K_DIM   = 3;
  localparam int IMG_W   = IMG_DIM * IMG_DIM * DW;
  localparam int KER_W   = K_DIM * K_DIM * DW;
  localparam int SUM_W   = DW + $clog2(IMG_DIM * IMG_DIM);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IMG_W-1:0] img_in = '0;
  logic [KER_W-1:0] ker_in = '0;
  logic             activate_done;
  logic             out_valid;
  logic             out_release = 1'b0;
  logic [IMG_W-1:0] img_out;
  logic [KER_W-1:0] ker_out;
  logic             out_bank;
  logic [1:0]       occupancy;
`ifdef OPERAND_SUM_EN
  logic [SUM_W-1:0] img_sum;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  conv_operand_pingpong #(.DW(DW), .IMG_DIM(IMG_DIM), .K_DIM(K_DIM)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .img_in        (img_in),
    .ker_in        (ker_in),
    .activate_done (activate_done),
    .out_valid     (out_valid),
    .out_release   (out_release),
    .img_out       (img_out),
    .ker_out       (ker_out),
    .out_bank      (out_bank),
    .occupancy     (occupancy)
`ifdef OPERAND_SUM_EN
    , .img_sum     (img_sum)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Two-slot FIFO of operand sets; slot index = bank. Contents persist after
  // release/clear, matching the stale-data rule.
  logic [IMG_W-1:0] m_img [2];
  logic [KER_W-1:0] m_ker [2];
  int               m_cnt;
  int               m_wr;
  int               m_rd;
  bit               m_ad;

  task automatic model_reset();
    m_img[0] = '0; m_img[1] = '0;
    m_ker[0] = '0; m_ker[1] = '0;
    m_cnt = 0; m_wr = 0; m_rd = 0; m_ad = 0;
  endtask

  task automatic model_step();
    bit take, give;
    take = in_valid && !clear && (m_cnt < 2);
    give = out_release && (m_cnt > 0) && !clear;
    if (clear) begin
      m_cnt = 0; m_wr = 0; m_rd = 0; m_ad = 0;
    end else begin
      if (take) begin
        m_img[m_wr] = img_in;
        m_ker[m_wr] = ker_in;
        m_wr = (m_wr + 1) % 2;
      end
      if (give) m_rd = (m_rd + 1) % 2;
      m_cnt = m_cnt + int'(take) - int'(give);
      m_ad  = take;
    end
  endtask

  function automatic logic [SUM_W-1:0] model_sum(input logic [IMG_W-1:0] img);
    int s = 0;
    for (int i = 0; i < IMG_DIM * IMG_DIM; i++) s += int'(img[i*DW +: DW]);
    return SUM_W'(s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; out_release = 1'b0; clear = 1'b0;
  endtask

  task automatic do_clear();
    idle(); clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic push(input logic [IMG_W-1:0] img, input logic [KER_W-1:0] ker);
    img_in = img; ker_in = ker; in_valid = 1'b1; tick(); in_valid = 1'b0;
  endtask

  function automatic logic [IMG_W-1:0] img_rows(input int v0, input int v1,
                                                input int v2, input int v3);
    logic [IMG_W-1:0] res;
    int v [4];
    v = '{v0, v1, v2, v3};
    res = '0;
    for (int r = 0; r < IMG_DIM; r++)
      for (int c = 0; c < IMG_DIM; c++) res[(r*IMG_DIM+c)*DW +: DW] = DW'(v[r]);
    return res;
  endfunction

  function automatic logic [KER_W-1:0] ker_rows(input int v0, input int v1, input int v2);
    logic [KER_W-1:0] res;
    int v [3];
    v = '{v0, v1, v2};
    res = '0;
    for (int r = 0; r < K_DIM; r++)
      for (int c = 0; c < K_DIM; c++) res[(r*K_DIM+c)*DW +: DW] = DW'(v[r]);
    return res;
  endfunction

  logic [IMG_W-1:0] img_a, img_b, img_c;
  logic [KER_W-1:0] ker_a, ker_b, ker_c;

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst = 1'b0; idle(); model_reset();
    tick(); tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b exp 1", in_ready); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL reset_occupancy: got %0d exp 0", occupancy); else n_pass++;
    n_checks++; if (img_out !== '0) $display("FAIL reset_img_out: got %0h exp 0", img_out); else n_pass++;
    n_checks++; if (ker_out !== '0) $display("FAIL reset_ker_out: got %0h exp 0", ker_out); else n_pass++;
    n_checks++; if (activate_done !== 1'b0) $display("FAIL reset_act: got %0b exp 0", activate_done); else n_pass++;
    n_checks++; if (out_bank !== 1'b0) $display("FAIL reset_out_bank: got %0b exp 0", out_bank); else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_single_capture();
    logic [DW-1:0] e;
    do_clear();
    push(img_a, ker_a);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_out_valid: got %0b exp 1", out_valid); else n_pass++;
    n_checks++; if (activate_done !== 1'b1) $display("FAIL single_act: got %0b exp 1", activate_done); else n_pass++;
    n_checks++; if (out_bank !== 1'b0) $display("FAIL single_out_bank: got %0b exp 0", out_bank); else n_pass++;
    e = img_out[(3*IMG_DIM+0)*DW +: DW];
    n_checks++; if (e !== 8'd14) $display("FAIL single_img_3_0: got %0d exp 14", e); else n_pass++;
    e = ker_out[(1*K_DIM+2)*DW +: DW];
    n_checks++; if (e !== 8'd2) $display("FAIL single_ker_1_2: got %0d exp 2", e); else n_pass++;
    n_checks++; if (img_out !== img_a) $display("FAIL single_img: got %0h exp %0h", img_out, img_a); else n_pass++;
`ifdef OPERAND_SUM_EN
    n_checks++; if (img_sum !== SUM_W'(120)) $display("FAIL single_sum: got %0d exp 120", img_sum); else n_pass++;
`endif
    tick();
    n_checks++; if (activate_done !== 1'b0) $display("FAIL single_act_once: got %0b exp 0", activate_done); else n_pass++;
    n_checks++; if (occupancy !== 2'd1) $display("FAIL single_occ: got %0d exp 1", occupancy); else n_pass++;
  endtask

  task automatic test_fill_backpressure();
    do_clear();
    push(img_a, ker_a);
    push(img_b, ker_b);
    n_checks++; if (occupancy !== 2'd2) $display("FAIL fill_occ: got %0d exp 2", occupancy); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %0b exp 0", in_ready); else n_pass++;
    push(img_c, ker_c);
    n_checks++; if (activate_done !== 1'b0) $display("FAIL fill_c_act: got %0b exp 0", activate_done); else n_pass++;
    n_checks++; if (img_out !== img_a) $display("FAIL fill_c_img: got %0h exp %0h", img_out, img_a); else n_pass++;
    out_release = 1'b1; tick(); out_release = 1'b0;
    n_checks++; if (img_out !== img_b) $display("FAIL fill_rel_img: got %0h exp %0h", img_out, img_b); else n_pass++;
    n_checks++; if (out_bank !== 1'b1) $display("FAIL fill_rel_bank: got %0b exp 1", out_bank); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL fill_rel_ready: got %0b exp 1", in_ready); else n_pass++;
    n_checks++; if (occupancy !== 2'd1) $display("FAIL fill_rel_occ: got %0d exp 1", occupancy); else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_clear();
    push(img_a, ker_a);
    img_in = img_b; ker_in = ker_b; in_valid = 1'b1; out_release = 1'b1;
    tick(); idle();
    n_checks++; if (occupancy !== 2'd1) $display("FAIL simul_occ: got %0d exp 1", occupancy); else n_pass++;
    n_checks++; if (out_bank !== 1'b1) $display("FAIL simul_bank: got %0b exp 1", out_bank); else n_pass++;
    n_checks++; if (img_out !== img_b) $display("FAIL simul_img: got %0h exp %0h", img_out, img_b); else n_pass++;
    n_checks++; if (activate_done !== 1'b1) $display("FAIL simul_act: got %0b exp 1", activate_done); else n_pass++;
    // Next capture must land in bank 0 (write pointer toggled too).
    out_release = 1'b1; tick(); out_release = 1'b0;
    push(img_c, ker_c);
    n_checks++; if (out_bank !== 1'b0 || img_out !== img_c) $display("FAIL simul_next_bank: got bank %0b img %0h exp bank 0 img %0h", out_bank, img_out, img_c); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_clear();
    push(img_a, ker_a);
    push(img_b, ker_b);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_out_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (occupancy !== 2'd0) $display("FAIL arst_occ: got %0d exp 0", occupancy); else n_pass++;
    n_checks++; if (img_out !== '0) $display("FAIL arst_img: got %0h exp 0", img_out); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push(img_b, ker_b);
    n_checks++; if (out_bank !== 1'b0) $display("FAIL arst_bank: got %0b exp 0", out_bank); else n_pass++;
    n_checks++; if (img_out !== img_b) $display("FAIL arst_img_b: got %0h exp %0h", img_out, img_b); else n_pass++;
  endtask

  task automatic test_clear();
    do_clear();
    // Move both pointers to 1 and fill: capture, release, capture, capture.
    push(img_a, ker_a);
    out_release = 1'b1; tick(); out_release = 1'b0;
    push(img_b, ker_b);
    push(img_a, ker_a);
    n_checks++; if (occupancy !== 2'd2 || out_bank !== 1'b1) $display("FAIL clear_setup: got occ %0d bank %0b exp occ 2 bank 1", occupancy, out_bank); else n_pass++;
    img_in = img_c; ker_in = ker_c; in_valid = 1'b1; out_release = 1'b1; clear = 1'b1;
    tick(); idle();
    n_checks++; if (occupancy !== 2'd0) $display("FAIL clear_occ: got %0d exp 0", occupancy); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL clear_out_valid: got %0b exp 0", out_valid); else n_pass++;
    n_checks++; if (activate_done !== 1'b0) $display("FAIL clear_act: got %0b exp 0", activate_done); else n_pass++;
    n_checks++; if (img_out !== img_a) $display("FAIL clear_stale_img: got %0h exp %0h", img_out, img_a); else n_pass++;
    push(img_c, ker_c);
    n_checks++; if (out_bank !== 1'b0) $display("FAIL clear_next_bank: got %0b exp 0", out_bank); else n_pass++;
    n_checks++; if (img_out !== img_c) $display("FAIL clear_next_img: got %0h exp %0h", img_out, img_c); else n_pass++;
  endtask

  task automatic test_random();
    do_clear();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < IMG_DIM * IMG_DIM; i++) img_in[i*DW +: DW] = DW'($urandom);
      for (int i = 0; i < K_DIM * K_DIM; i++) ker_in[i*DW +: DW] = DW'($urandom);
      in_valid    = ($urandom_range(0, 99) < 55);
      out_release = ($urandom_range(0, 99) < 45);
      clear       = ($urandom_range(0, 99) < 4);
      tick();
      n_checks++; if (occupancy !== 2'(m_cnt)) $display("FAIL rand_occ[%0d]: got %0d exp %0d", n, occupancy, m_cnt); else n_pass++;
      n_checks++; if (out_valid !== (m_cnt != 0)) $display("FAIL rand_out_valid[%0d]: got %0b exp %0b", n, out_valid, m_cnt != 0); else n_pass++;
      n_checks++; if (out_bank !== 1'(m_rd)) $display("FAIL rand_bank[%0d]: got %0b exp %0d", n, out_bank, m_rd); else n_pass++;
      n_checks++; if (img_out !== m_img[m_rd]) $display("FAIL rand_img[%0d]: got %0h exp %0h", n, img_out, m_img[m_rd]); else n_pass++;
      n_checks++; if (ker_out !== m_ker[m_rd]) $display("FAIL rand_ker[%0d]: got %0h exp %0h", n, ker_out, m_ker[m_rd]); else n_pass++;
      n_checks++; if (activate_done !== m_ad) $display("FAIL rand_act[%0d]: got %0b exp %0b", n, activate_done, m_ad); else n_pass++;
      n_checks++; if (in_ready !== (!clear && m_cnt < 2)) $display("FAIL rand_in_ready[%0d]: got %0b exp %0b", n, in_ready, !clear && m_cnt < 2); else n_pass++;
`ifdef OPERAND_SUM_EN
      n_checks++; if (img_sum !== model_sum(m_img[m_rd])) $display("FAIL rand_sum[%0d]: got %0d exp %0d", n, img_sum, model_sum(m_img[m_rd])); else n_pass++;
`endif
    end
    idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    img_a = img_rows(3, 4, 9, 14);
    ker_a = ker_rows(11, 2, 9);
    img_b = img_rows(1, 1, 1, 1);
    ker_b = ker_rows(1, 1, 1);
    img_c = img_rows(7, 7, 7, 7);
    ker_c = ker_rows(5, 5, 5);
    test_reset();
    test_single_capture();
    test_fill_backpressure();
    test_simultaneous();
    test_async_reset();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
